// File: rtl/alu_sequencer.sv
// alu_sequencer
// Control-side companion of the 8-bit ALU. Accepts one 9-bit instruction per
// valid/ready handshake and latches it. It drives the decoded ALU fields,
// register read addresses and immediate for one EXEC cycle. At the end of
// that cycle it commits the register write, the flag update or the branch.
// A HALT instruction parks the sequencer until reset.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   instr_valid, instr      fetch side offer (9-bit instruction)
//   instr_ready             sequencer can accept this cycle
//   alu_type/m_op/c_op/a_op/v_op, alu_sc_i
//                           ALU operation fields and carry-in (EXEC only)
//   ra_addr, rb_addr        register-file read ports (A feeds inA, B feeds inB)
//   imm_sel, imm_val        inA mux select and zero-extended immediate
//   alu_rslt, alu_sc_o      ALU result and carry-out
//   wr_en, wr_addr, wr_data register write, one-cycle pulse
//   br_taken, br_idx        branch pulse and target LUT index
//   flag_c, flag_z, flag_p  flag register
//   halted                  HALT reached
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    output logic [1:0] alu_type,
    output logic [2:0] alu_m_op,
    output logic [1:0] alu_c_op,
    output logic [2:0] alu_a_op,
    output logic       alu_v_op,
    output logic       alu_sc_i,
    output logic [1:0] ra_addr,
    output logic [1:0] rb_addr,
    output logic       imm_sel,
    output logic [7:0] imm_val,
    input  logic [7:0] alu_rslt,
    input  logic       alu_sc_o,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       br_taken,
    output logic [4:0] br_idx,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_p,
    output logic       halted
);

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0] typ;
        logic [2:0] m_op;
        logic [1:0] c_op;
        logic [2:0] a_op;
        logic       v_op;
        logic       sc_i;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       imm_sel;
        logic [7:0] imm;
    } dec_t;

    state_t     state_r;
    logic [8:0] ir_r;
    dec_t       dec_r;
    logic       cond_s;
    logic       z_s;
    logic       p_s;

    // Even-parity bit of a data byte: 1 when an odd number of bits are set.
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    // Decode a raw instruction into the ALU-facing fields. The carry-in is
    // captured together with the fields so that it reflects the flags
    // committed by the previous instruction.
    function automatic dec_t decode_instr(input logic [8:0] ins, input logic c);
        dec_t d;
        d     = '0;
        d.typ = ins[8:7];
        case (ins[8:7])
            2'b00: begin
                d.m_op = ins[6:4];
                d.ra   = ins[3:2];
                d.rb   = ins[1:0];
                // ADD (000) and SUB (001) chain the carry flag
                d.sc_i = (ins[6:5] == 2'b00) ? c : 1'b0;
            end
            2'b01: begin
                d.c_op = ins[6:5];
            end
            2'b10: begin
                d.a_op = ins[6:4];
                d.ra   = ins[3:2];
                d.rb   = ins[1:0];
                // CMP subtracts with borrow-in from the carry flag
                d.sc_i = (ins[6:4] == 3'b100) ? c : 1'b0;
            end
            2'b11: begin
                if (ins[6]) begin
                    d.imm_sel = 1'b1;
                    d.imm     = {4'b0000, ins[3:0]};
                end else begin
                    d.ra = ins[1:0];
                end
            end
            default: begin
                d = '0;
            end
        endcase
        return d;
    endfunction

    // Flag candidates and branch condition for the instruction in EXEC.
    always_comb begin
        z_s    = (alu_rslt == 8'h00);
        p_s    = parity8(alu_rslt);
        cond_s = 1'b0;
        case (ir_r[6:5])
            2'b00:   cond_s = flag_z;
            2'b01:   cond_s = ~flag_z;
            2'b10:   cond_s = flag_c;
            2'b11:   cond_s = 1'b1;
            default: cond_s = 1'b0;
        endcase
    end

    // Issue/execute sequencer with registered decode, writeback, branch and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_READY;
            ir_r     <= 9'b0;
            dec_r    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= 2'b00;
            wr_data  <= 8'h00;
            br_taken <= 1'b0;
            br_idx   <= 5'b0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            flag_p   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            // write and branch strobes are single-cycle pulses
            wr_en    <= 1'b0;
            br_taken <= 1'b0;
            case (state_r)
                ST_READY: begin
                    if (instr_valid) begin
                        ir_r    <= instr;
                        dec_r   <= decode_instr(instr, flag_c);
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_READY;
                    end
                end
                ST_EXEC: begin
                    dec_r   <= '0;
                    state_r <= ST_READY;
                    case (ir_r[8:7])
                        2'b00: begin
                            wr_en   <= 1'b1;
                            wr_addr <= ir_r[3:2];
                            wr_data <= alu_rslt;
                            flag_z  <= z_s;
                            flag_p  <= p_s;
                            if (ir_r[6:5] == 2'b00) begin
                                flag_c <= alu_sc_o;
                            end
                        end
                        2'b01: begin
                            if (cond_s) begin
                                br_taken <= 1'b1;
                                br_idx   <= ir_r[4:0];
                            end
                        end
                        2'b10: begin
                            case (ir_r[6:4])
                                3'b100: begin
                                    flag_c <= alu_sc_o;
                                    flag_z <= z_s;
                                    flag_p <= p_s;
                                end
                                3'b000:  flag_c <= 1'b0;
                                3'b001:  flag_c <= 1'b1;
                                3'b111: begin
                                    halted  <= 1'b1;
                                    state_r <= ST_HALT;
                                end
                                default: begin
                                    // NOP encodings leave all state untouched
                                end
                            endcase
                        end
                        2'b11: begin
                            wr_en   <= 1'b1;
                            wr_addr <= ir_r[6] ? ir_r[5:4] : ir_r[3:2];
                            wr_data <= alu_rslt;
                        end
                        default: begin
                            state_r <= ST_READY;
                        end
                    endcase
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_READY;
                end
            endcase
        end
    end

    // Ready is forced low while reset is held, even though the state is READY.
    assign instr_ready = rst_n & (state_r == ST_READY);

    assign alu_type = dec_r.typ;
    assign alu_m_op = dec_r.m_op;
    assign alu_c_op = dec_r.c_op;
    assign alu_a_op = dec_r.a_op;
    assign alu_v_op = dec_r.v_op;
    assign alu_sc_i = dec_r.sc_i;
    assign ra_addr  = dec_r.ra;
    assign rb_addr  = dec_r.rb;
    assign imm_sel  = dec_r.imm_sel;
    assign imm_val  = dec_r.imm;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a register file and ALU around the DUT, a
// directed vector table, hand-written reset/HALT/back-to-back sequences and
// a randomized run against an instruction-level reference model.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [1:0] alu_type;
    logic [2:0] alu_m_op;
    logic [1:0] alu_c_op;
    logic [2:0] alu_a_op;
    logic       alu_v_op;
    logic       alu_sc_i;
    logic [1:0] ra_addr;
    logic [1:0] rb_addr;
    logic       imm_sel;
    logic [7:0] imm_val;
    logic [7:0] alu_rslt;
    logic       alu_sc_o;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       br_taken;
    logic [4:0] br_idx;
    logic       flag_c;
    logic       flag_z;
    logic       flag_p;
    logic       halted;

    int total = 0;
    int bad   = 0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_type(alu_type), .alu_m_op(alu_m_op),
        .alu_c_op(alu_c_op), .alu_a_op(alu_a_op), .alu_v_op(alu_v_op),
        .alu_sc_i(alu_sc_i), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .imm_sel(imm_sel), .imm_val(imm_val), .alu_rslt(alu_rslt),
        .alu_sc_o(alu_sc_o), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .br_taken(br_taken), .br_idx(br_idx),
        .flag_c(flag_c), .flag_z(flag_z), .flag_p(flag_p), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- environment: register file + ALU ----------------
    logic [7:0] rf [4];
    logic       poke;
    logic [1:0] poke_a;
    logic [7:0] poke_d;
    logic [7:0] in_a;

    always @(posedge clk) begin
        if (poke) rf[poke_a] <= poke_d;
        else if (wr_en) rf[wr_addr] <= wr_data;
    end

    function automatic logic [8:0] alu_fn(input logic [1:0] t, input logic [2:0] mop,
                                          input logic [2:0] aop, input logic cin,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = 9'h000;
        case (t)
            2'b00: begin
                case (mop)
                    3'd0:    r = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                    3'd1:    r = {1'b0, a} - {1'b0, b} - {8'h00, cin};
                    3'd2:    r = {1'b0, a & b};
                    3'd3:    r = {1'b0, a | b};
                    3'd4:    r = {1'b0, a ^ b};
                    3'd5:    r = {1'b1, ~a};
                    3'd6:    r = {a, 1'b0};
                    default: r = {a[0], 1'b0, a[7:1]};
                endcase
            end
            2'b10:   r = (aop == 3'b100) ? ({1'b0, a} - {1'b0, b} - {8'h00, cin}) : 9'h000;
            2'b11:   r = {1'b0, a};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    always_comb begin
        in_a = imm_sel ? imm_val : rf[ra_addr];
        {alu_sc_o, alu_rslt} = alu_fn(alu_type, alu_m_op, alu_a_op, alu_sc_i, in_a, rf[rb_addr]);
    end

    // ---------------- reference model state ----------------
    logic [7:0] m_rf [4];
    logic       m_c, m_z, m_p;
    logic       e_we, e_br, e_sc;
    logic [1:0] e_wa;
    logic [7:0] e_wd;
    logic [4:0] e_idx;

    // observations captured by issue()
    logic       prev_pulse, ex_ready, ex_sc, o_we, o_br, o_halted, o_ready;
    logic [1:0] ex_type, o_wa;
    logic [7:0] o_wd;
    logic [4:0] o_idx;
    logic [2:0] o_flags;
    logic [24:0] o_dec;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_c = 1'b0; m_z = 1'b0; m_p = 1'b0;
    endtask

    task automatic set_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        poke = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        poke = 1'b0;
        m_rf[a] = d;
    endtask

    // Offer one instruction, observe the EXEC cycle and the cycle after it.
    task automatic issue(input logic [8:0] ins);
        int n;
        @(negedge clk);
        prev_pulse = wr_en | br_taken;
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, {31'b0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 9'($urandom);
        ex_ready = instr_ready;
        ex_type  = alu_type;
        ex_sc    = alu_sc_i;
        @(negedge clk);
        o_we = wr_en; o_wa = wr_addr; o_wd = wr_data;
        o_br = br_taken; o_idx = br_idx;
        o_flags = {flag_c, flag_z, flag_p};
        o_halted = halted; o_ready = instr_ready;
        o_dec = {alu_type, alu_m_op, alu_c_op, alu_a_op, alu_v_op, alu_sc_i,
                 ra_addr, rb_addr, imm_sel, imm_val};
    endtask

    // Instruction-level model: expected effects and new architectural state.
    task automatic model_step(input logic [8:0] ins);
        logic [8:0] r;
        logic [7:0] a, b;
        logic       cin;
        e_we = 1'b0; e_wa = 2'b00; e_wd = 8'h00; e_br = 1'b0; e_idx = 5'd0; e_sc = 1'b0;
        a = m_rf[ins[3:2]];
        b = m_rf[ins[1:0]];
        case (ins[8:7])
            2'b00: begin
                cin  = (ins[6:4] <= 3'd1) ? m_c : 1'b0;
                e_sc = cin;
                r = alu_fn(2'b00, ins[6:4], 3'b000, cin, a, b);
                e_we = 1'b1; e_wa = ins[3:2]; e_wd = r[7:0];
                m_z = (r[7:0] == 8'h00); m_p = ^r[7:0];
                if (ins[6:4] <= 3'd1) m_c = r[8];
            end
            2'b01: begin
                e_idx = ins[4:0];
                case (ins[6:5])
                    2'b00:   e_br = m_z;
                    2'b01:   e_br = !m_z;
                    2'b10:   e_br = m_c;
                    default: e_br = 1'b1;
                endcase
            end
            2'b10: begin
                if (ins[6:4] == 3'b100) begin
                    e_sc = m_c;
                    r = {1'b0, a} - {1'b0, b} - {8'h00, m_c};
                    m_c = r[8]; m_z = (r[7:0] == 8'h00); m_p = ^r[7:0];
                end else if (ins[6:4] == 3'b000) m_c = 1'b0;
                else if (ins[6:4] == 3'b001) m_c = 1'b1;
            end
            default: begin
                e_we = 1'b1;
                if (ins[6]) begin
                    e_wa = ins[5:4]; e_wd = {4'h0, ins[3:0]};
                end else begin
                    e_wa = ins[3:2]; e_wd = m_rf[ins[1:0]];
                end
            end
        endcase
        if (e_we) m_rf[e_wa] = e_wd;
    endtask

    typedef struct packed {
        logic [8:0] ins;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       br;
        logic [4:0] idx;
        logic       c, z, p;
    } vec_t;

    vec_t vecs [19];
    logic [6:0] b2b_rdy, b2b_wr;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // ins, we, wa, wd, br, idx, c, z, p
        vecs[0]  = '{9'b000000110, 1'b1, 2'd1, 8'h10, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1}; // ADD 1,2
        vecs[1]  = '{9'b100000000, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1}; // CLC
        vecs[2]  = '{9'b111010101, 1'b1, 2'd1, 8'h05, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1}; // LDI r1,5
        vecs[3]  = '{9'b111100101, 1'b1, 2'd2, 8'h05, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1}; // LDI r2,5
        vecs[4]  = '{9'b101000110, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0}; // CMP 1,2
        vecs[5]  = '{9'b010001010, 1'b0, 2'd0, 8'h00, 1'b1, 5'h0A, 1'b0, 1'b1, 1'b0}; // BZ 0A
        vecs[6]  = '{9'b010101011, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0}; // BNZ
        vecs[7]  = '{9'b111111010, 1'b1, 2'd3, 8'h0A, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0}; // LDI r3,A
        vecs[8]  = '{9'b100010000, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0}; // SEC
        vecs[9]  = '{9'b011010101, 1'b0, 2'd0, 8'h00, 1'b1, 5'h15, 1'b1, 1'b1, 1'b0}; // BC 15
        vecs[10] = '{9'b110000011, 1'b1, 2'd0, 8'h0A, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0}; // MOV r0,r3
        vecs[11] = '{9'b100000000, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0}; // CLC
        vecs[12] = '{9'b011111111, 1'b0, 2'd0, 8'h00, 1'b1, 5'h1F, 1'b0, 1'b1, 1'b0}; // JMP 1F
        vecs[13] = '{9'b100010000, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0}; // SEC
        vecs[14] = '{9'b000011101, 1'b1, 2'd3, 8'h04, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1}; // SUB 3,1
        vecs[15] = '{9'b000000000, 1'b1, 2'd0, 8'h14, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0}; // ADD 0,0
        vecs[16] = '{9'b100010000, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0}; // SEC
        vecs[17] = '{9'b001000000, 1'b1, 2'd0, 8'h00, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0}; // XOR 0,0
        vecs[18] = '{9'b100100000, 1'b0, 2'd0, 8'h00, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0}; // NOP

        poke = 1'b0; poke_a = 2'b00; poke_d = 8'h00;
        instr = 9'b0; instr_valid = 1'b0;

        // ---- reset values ----
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, {31'b0, instr_ready}, 32'd0);
        chk("rst_outs", 0, {wr_en, br_taken, flag_c, flag_z, flag_p, halted}, 32'd0);
        chk("rst_regs", 0, {wr_addr, wr_data, br_idx}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 1, {31'b0, instr_ready}, 32'd1);
        chk("rst_dec", 0, {alu_type, alu_m_op, alu_c_op, alu_a_op, alu_v_op, alu_sc_i,
                           ra_addr, rb_addr, imm_sel, imm_val}, 32'd0);
        m_c = 1'b0; m_z = 1'b0; m_p = 1'b0;

        // ---- directed vector table ----
        set_reg(2'd0, 8'h00);
        set_reg(2'd1, 8'hF0);
        set_reg(2'd2, 8'h20);
        set_reg(2'd3, 8'h00);
        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].ins);
            if (i > 0) chk("vec_pulse_width", i, {31'b0, prev_pulse}, 32'd0);
            chk("vec_exec_ready", i, {31'b0, ex_ready}, 32'd0);
            chk("vec_exec_type", i, {30'b0, ex_type}, {30'b0, vecs[i].ins[8:7]});
            chk("vec_wr_en", i, {31'b0, o_we}, {31'b0, vecs[i].we});
            if (vecs[i].we) begin
                chk("vec_wr_addr", i, {30'b0, o_wa}, {30'b0, vecs[i].wa});
                chk("vec_wr_data", i, {24'b0, o_wd}, {24'b0, vecs[i].wd});
            end
            chk("vec_br", i, {31'b0, o_br}, {31'b0, vecs[i].br});
            if (vecs[i].br) chk("vec_br_idx", i, {27'b0, o_idx}, {27'b0, vecs[i].idx});
            chk("vec_flags", i, {29'b0, o_flags}, {29'b0, vecs[i].c, vecs[i].z, vecs[i].p});
            chk("vec_dec_idle", i, {7'b0, o_dec}, 32'd0);
            chk("vec_ready_again", i, {31'b0, o_ready}, 32'd1);
        end

        // ---- back-to-back issue: valid held over three instructions ----
        do_reset();
        b2b_rdy = 7'b1010101;
        b2b_wr  = 7'b1010100;
        @(negedge clk);
        instr = 9'b000100000;
        instr_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) instr_valid = 1'b0;
            chk("b2b_ready", k, {31'b0, instr_ready}, {31'b0, b2b_rdy[k]});
            chk("b2b_wr_en", k, {31'b0, wr_en}, {31'b0, b2b_wr[k]});
        end

        // ---- reset in the EXEC cycle of an ADD ----
        do_reset();
        issue(9'b100010000);
        chk("mid_pre_c", 0, {31'b0, o_flags[2]}, 32'd1);
        @(negedge clk);
        instr = 9'b000000000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_exec_ready", 0, {31'b0, instr_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_flags", 0, {29'b0, flag_c, flag_z, flag_p}, 32'd0);
        @(negedge clk);
        chk("mid_no_pulse", 0, {30'b0, wr_en, br_taken}, 32'd0);
        rst_n = 1'b1;
        m_c = 1'b0; m_z = 1'b0; m_p = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mid_after_ready", k, {31'b0, instr_ready}, 32'd1);
            chk("mid_after_pulse", k, {30'b0, wr_en, br_taken}, 32'd0);
        end

        // ---- HALT, further offers ignored, exit only by reset ----
        do_reset();
        issue(9'b101110000);
        chk("halt_rise", 0, {31'b0, o_halted}, 32'd1);
        chk("halt_ready", 0, {31'b0, o_ready}, 32'd0);
        instr = 9'b000000110;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt_hold", k, {29'b0, halted, instr_ready, wr_en}, 32'd4);
            chk("halt_dec", k, {30'b0, alu_type}, 32'd0);
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt_rst", 0, {30'b0, halted, instr_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_c = 1'b0; m_z = 1'b0; m_p = 1'b0;
        #1;
        chk("halt_rst_ready", 0, {31'b0, instr_ready}, 32'd1);

        // ---- randomized run against the reference model ----
        for (int a = 0; a < 4; a++) set_reg(2'(a), 8'($urandom));
        for (int i = 0; i < 200; i++) begin
            logic [8:0] ins;
            ins = 9'($urandom);
            if (ins[8:7] == 2'b10 && ins[6:4] == 3'b111) ins[6:4] = 3'b010;
            model_step(ins);
            issue(ins);
            chk("rnd_pulse_width", i, {31'b0, prev_pulse}, 32'd0);
            chk("rnd_sc_i", i, {31'b0, ex_sc}, {31'b0, e_sc});
            chk("rnd_wr_en", i, {31'b0, o_we}, {31'b0, e_we});
            if (e_we) chk("rnd_wr", i, {22'b0, o_wa, o_wd}, {22'b0, e_wa, e_wd});
            chk("rnd_br", i, {31'b0, o_br}, {31'b0, e_br});
            if (e_br) chk("rnd_br_idx", i, {27'b0, o_idx}, {27'b0, e_idx});
            chk("rnd_flags", i, {29'b0, o_flags}, {29'b0, m_c, m_z, m_p});
            chk("rnd_halted", i, {31'b0, o_halted}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
